// File: rtl/wb_seg_reg_pc_if.sv
// Bus bundle between the MEM stage and the writeback segment register.
// The slave modport is the register's view; the master modport is the driver's view.
interface wb_seg_reg_pc_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned RW_W   = 3,
  parameter int unsigned CNT_W  = 32
);
  logic                cache_miss;
  logic [ADDR_W-1:0]   addr_m;
  logic [DATA_W/8-1:0] we_m;
  logic                mem_to_reg_m;
  logic [DATA_W-1:0]   rd_data_raw;
  logic [DATA_W-1:0]   result_m;
  logic [RD_W-1:0]     rd_m;
  logic [RW_W-1:0]     reg_write_m;

  logic [DATA_W-1:0]   rd_data;
  logic [1:0]          loaded_bytes_sel;
  logic [DATA_W-1:0]   result_w;
  logic [RD_W-1:0]     rd_w;
  logic [RW_W-1:0]     reg_write_w;
  logic                mem_to_reg_w;
  logic [CNT_W-1:0]    hit_count;
  logic [CNT_W-1:0]    miss_count;
  logic [CNT_W-1:0]    access_count;

  modport slave (
    input  cache_miss, addr_m, we_m, mem_to_reg_m, rd_data_raw, result_m, rd_m, reg_write_m,
    output rd_data, loaded_bytes_sel, result_w, rd_w, reg_write_w, mem_to_reg_w,
    output hit_count, miss_count, access_count
  );

  modport master (
    output cache_miss, addr_m, we_m, mem_to_reg_m, rd_data_raw, result_m, rd_m, reg_write_m,
    input  rd_data, loaded_bytes_sel, result_w, rd_w, reg_write_w, mem_to_reg_w,
    input  hit_count, miss_count, access_count
  );
endinterface

// File: rtl/wb_seg_reg_pc.sv
// Writeback segment register with stall/flush, load-data hold and hit/miss counters.
// Define WB_PERF_CNT_EN to build the performance counters; otherwise they read as zero.
module wb_seg_reg_pc #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned RW_W   = 3,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   cnt_clr,
  wb_seg_reg_pc_if.slave         bus
);

  typedef enum logic [0:0] {StPass, StHold} hold_state_e;

  hold_state_e       state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [1:0]        sel_q;
  logic [DATA_W-1:0] result_q;
  logic [RD_W-1:0]   rd_q;
  logic [RW_W-1:0]   reg_write_q;
  logic              mem_to_reg_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sel_q        <= '0;
      result_q     <= '0;
      rd_q         <= '0;
      reg_write_q  <= '0;
      mem_to_reg_q <= 1'b0;
    end else if (en) begin
      sel_q        <= bus.addr_m[1:0];
      result_q     <= bus.result_m;
      rd_q         <= bus.rd_m;
      reg_write_q  <= bus.reg_write_m;
      mem_to_reg_q <= bus.mem_to_reg_m;
    end
  end

  assign bus.loaded_bytes_sel = sel_q;
  assign bus.result_w         = result_q;
  assign bus.rd_w             = rd_q;
  assign bus.reg_write_w      = reg_write_q;
  assign bus.mem_to_reg_w     = mem_to_reg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StPass;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Capture the load data seen on the first stalled edge and replay it until the stall ends.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    bus.rd_data = bus.rd_data_raw;
    unique case (state_q)
      StPass: begin
        if (!en) begin
          state_d = StHold;
          hold_d  = bus.rd_data_raw;
        end
      end
      StHold: begin
        bus.rd_data = hold_q;
        if (en) state_d = StPass;
      end
      default: state_d = StPass;
    endcase
    if (clear) begin
      state_d = StPass;
      hold_d  = '0;
    end
  end

  logic unused_addr;
  assign unused_addr = ^bus.addr_m[ADDR_W-1:2];

`ifdef WB_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             req, complete;
  logic             miss_seen_q, miss_seen_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d, acc_q, acc_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CntOne;
  endfunction

  assign req      = bus.mem_to_reg_m | (|bus.we_m);
  assign complete = req & en & ~bus.cache_miss & ~clear;

  always_comb begin
    miss_seen_d = miss_seen_q;
    if (clear || complete) begin
      miss_seen_d = 1'b0;
    end else if (req && bus.cache_miss) begin
      miss_seen_d = 1'b1;
    end
  end

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    acc_d  = acc_q;
    if (cnt_clr) begin
      hit_d  = '0;
      miss_d = '0;
      acc_d  = '0;
    end else if (complete) begin
      acc_d = sat_inc(acc_q);
      if (miss_seen_q) miss_d = sat_inc(miss_q);
      else             hit_d  = sat_inc(hit_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_seen_q <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
      acc_q       <= '0;
    end else begin
      miss_seen_q <= miss_seen_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.hit_count    = hit_q;
  assign bus.miss_count   = miss_q;
  assign bus.access_count = acc_q;
`else
  logic unused_perf;
  assign unused_perf = ^{cnt_clr, bus.cache_miss, bus.we_m};

  assign bus.hit_count    = '0;
  assign bus.miss_count   = '0;
  assign bus.access_count = '0;
`endif

endmodule
